// File: rtl/rx_port_arbiter.sv
// rx_port_arbiter: round-robin drain of N rx ports into one registered output slot.
// A granted port's flit is captured on the clock edge while its item_read pulses
// combinationally in the same cycle; the slot supports zero-bubble back-to-back
// transfers when the downstream stage accepts and another port is requesting.

`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 32
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 8
`endif

module rx_port_arbiter #(
   parameter int N         = 5,
   parameter int PORT_BITS = 3,
   parameter int routerid  = -1
) (
   input  logic                                     rclk,
   input  logic                                     reset,
   input  logic [N-1:0]                             rx_valid,
   input  logic [N*(`PAYLOAD_SIZE+`ADDR_BITS)-1:0]  rx_data,
   input  logic [N-1:0]                             port_mask,
   output logic [N-1:0]                             rx_item_read,
   output logic                                     out_valid,
   output logic [`PAYLOAD_SIZE+`ADDR_BITS-1:0]      out_data,
   output logic [PORT_BITS-1:0]                     out_port,
   input  logic                                     out_ready
);

   localparam int W = `PAYLOAD_SIZE + `ADDR_BITS;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;

   // Reject port counts the index width cannot address; routerid -1 means unassigned.
   if (N < 1 || N > 8 || (1 << PORT_BITS) < N || routerid < -1) begin : g_param_check
      $error("rx_port_arbiter: illegal parameters N=%0d PORT_BITS=%0d routerid=%0d",
             N, PORT_BITS, routerid);
   end

   logic [0:0]           state;
   logic [PORT_BITS-1:0] rr_ptr;
   logic [PORT_BITS-1:0] rr_next;
   logic [N-1:0]         req;
   logic                 req_any;
   logic                 found;
   logic [PORT_BITS-1:0] grant;
   logic [W-1:0]         grant_data;
   logic                 cap;

   assign req     = rx_valid & port_mask;
   assign req_any = |req;

   // Slot can take a new flit when empty, or when the held flit leaves this cycle.
   assign cap = ((state == IDLE) || out_ready) && req_any;

   // Pointer moves just past the granted port, wrapping at N-1.
   assign rr_next = (int'(grant) == N - 1) ? '0 : grant + 1'b1;

   assign out_valid = (state == HOLD);

   // Rotating priority: scan rr_ptr..N-1 first, then wrap and scan 0..N-1.
   always_comb begin
      found = 1'b0;
      grant = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!found && req[i] && (i >= 32'(rr_ptr))) begin
            found = 1'b1;
            grant = PORT_BITS'(i);
         end
      end
      for (int unsigned i = 0; i < N; i++) begin
         if (!found && req[i]) begin
            found = 1'b1;
            grant = PORT_BITS'(i);
         end
      end
   end

   // Select the granted port's flit.
   always_comb begin
      grant_data = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (grant == PORT_BITS'(i)) begin
            grant_data = rx_data[i*W +: W];
         end
      end
   end

   // One-hot read pulse to the granted port; held off while reset is asserted.
   always_comb begin
      rx_item_read = '0;
      for (int unsigned i = 0; i < N; i++) begin
         rx_item_read[i] = cap && reset && (grant == PORT_BITS'(i));
      end
   end

   // Slot state, captured flit and round-robin pointer.
   always_ff @(posedge rclk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         out_data <= '0;
         out_port <= '0;
         rr_ptr   <= '0;
      end else if (cap) begin
         state    <= HOLD;
         out_data <= grant_data;
         out_port <= grant;
         rr_ptr   <= rr_next;
      end else if ((state == HOLD) && out_ready) begin
         state    <= IDLE;
      end
   end

   a_read_onehot: assert property (@(posedge rclk) disable iff (!reset)
      $onehot0(rx_item_read));

   a_ptr_range: assert property (@(posedge rclk) disable iff (!reset)
      int'(rr_ptr) < N);

   a_hold_stable: assert property (@(posedge rclk) disable iff (!reset)
      (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_port)));

endmodule
